rib_xbar: RTL and testbench



---
 rtl/rib_xbar_pkg.sv | 16 +
 rtl/rib_rr_arbiter.sv | 31 +++
 rtl/rib_xbar.sv | 180 ++++++++++++++++++
 tb/tb_rib_xbar.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_xbar_pkg.sv
// Shared definitions for the RIB crossbar: bus widths, slave-select field and FSM states.
package rib_xbar_pkg;

  localparam int unsigned RIB_ADDR_W  = 32;
  localparam int unsigned RIB_DATA_W  = 32;
  localparam int unsigned RIB_SEL_MSB = 31;
  localparam int unsigned RIB_SEL_LSB = 28;
  localparam int unsigned RIB_SEL_W   = RIB_SEL_MSB - RIB_SEL_LSB + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } rib_state_e;

endpackage

// File: rtl/rib_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past i_ptr and wraps modulo NUM_M.
module rib_rr_arbiter #(
  parameter int unsigned NUM_M = 4
) (
  input  logic [NUM_M-1:0]         i_req,
  input  logic [$clog2(NUM_M)-1:0] i_ptr,
  output logic [NUM_M-1:0]         o_gnt,
  output logic [$clog2(NUM_M)-1:0] o_idx
);

  localparam int unsigned IW = $clog2(NUM_M);

  int unsigned w_c;
  logic        w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_c     = 0;
    for (int unsigned i = 1; i <= NUM_M; i++) begin
      w_c = (32'(i_ptr) + i) % NUM_M;
      if (!w_found && i_req[w_c]) begin
        o_gnt[w_c] = 1'b1;
        o_idx      = w_c[IW-1:0];
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rib_xbar.sv
// NUM_M x NUM_S RIB interconnect with round-robin arbitration and registered handshake.
// Optional wait-state timeout is compiled in with RIB_TIMEOUT_EN.
module rib_xbar
  import rib_xbar_pkg::*;
#(
  parameter int unsigned      NUM_M       = 4,
  parameter int unsigned      NUM_S       = 6,
  parameter logic [NUM_M-1:0] HOLD_MASK   = 4'b1101,
  parameter int unsigned      TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_M-1:0]      m_req_i,
  input  logic [32*NUM_M-1:0]   m_addr_i,
  input  logic [32*NUM_M-1:0]   m_data_i,
  input  logic [NUM_M-1:0]      m_we_i,
  output logic [31:0]           m_data_o,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic                  m_err_o,
  output logic [NUM_S-1:0]      s_req_o,
  output logic [31:0]           s_addr_o,
  output logic [31:0]           s_data_o,
  output logic                  s_we_o,
  input  logic [32*NUM_S-1:0]   s_data_i,
  input  logic [NUM_S-1:0]      s_ack_i,
  output logic                  hold_flag_o
);

  localparam int unsigned IW = $clog2(NUM_M);

  rib_state_e             r_state;
  logic [IW-1:0]          r_owner;
  logic [IW-1:0]          r_rr_ptr;
  logic [RIB_ADDR_W-1:0]  r_addr;
  logic [RIB_DATA_W-1:0]  r_wdata;
  logic                   r_we;
  logic [NUM_S-1:0]       r_s_req;
  logic                   r_s_we;
  logic [NUM_M-1:0]       r_m_ack;
  logic [RIB_DATA_W-1:0]  r_m_data;
  logic                   r_m_err;

  logic [NUM_M-1:0]       w_gnt;
  logic [IW-1:0]          w_gnt_idx;
  logic [RIB_ADDR_W-1:0]  w_addr;
  logic [RIB_DATA_W-1:0]  w_wdata;
  logic                   w_we;
  logic [NUM_S-1:0]       w_s_hit;
  logic [NUM_M-1:0]       w_owner_oh;
  logic                   w_s_ack;
  logic [RIB_DATA_W-1:0]  w_rdata;

`ifdef RIB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wait_cnt;
`endif

  rib_rr_arbiter #(
    .NUM_M (NUM_M)
  ) u_arb (
    .i_req (m_req_i),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx)
  );

  // Request fields of the arbitration winner, and the slave it addresses.
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (w_gnt[k]) begin
        w_addr  = m_addr_i[32*k +: 32];
        w_wdata = m_data_i[32*k +: 32];
        w_we    = m_we_i[k];
      end
    end
    w_s_hit = '0;
    for (int s = 0; s < NUM_S; s++) begin
      w_s_hit[s] = (w_addr[RIB_SEL_MSB:RIB_SEL_LSB] == RIB_SEL_W'(s));
    end
  end

  // r_s_req is only non-zero in BUSY, so it doubles as the latched slave select.
  always_comb begin
    w_s_ack = |(s_ack_i & r_s_req);
    w_rdata = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (r_s_req[s]) w_rdata = w_rdata | s_data_i[32*s +: 32];
    end
    w_owner_oh = '0;
    for (int k = 0; k < NUM_M; k++) begin
      w_owner_oh[k] = (r_owner == IW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_owner  <= '0;
      r_rr_ptr <= IW'(NUM_M - 1);
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_s_req  <= '0;
      r_s_we   <= 1'b0;
      r_m_ack  <= '0;
      r_m_data <= '0;
      r_m_err  <= 1'b0;
`ifdef RIB_TIMEOUT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|m_req_i) begin
            r_owner <= w_gnt_idx;
            r_addr  <= {{RIB_SEL_W{1'b0}}, w_addr[RIB_SEL_LSB-1:0]};
            r_wdata <= w_wdata;
            r_we    <= w_we;
`ifdef RIB_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
            if (|w_s_hit) begin
              r_state <= StBusy;
              r_s_req <= w_s_hit;
              r_s_we  <= w_we;
            end else begin
              // Decode error: answer directly without touching any slave.
              r_state  <= StResp;
              r_m_ack  <= w_gnt;
              r_m_data <= '0;
              r_m_err  <= 1'b1;
            end
          end
        end
        StBusy: begin
          if (w_s_ack) begin
            r_state  <= StResp;
            r_s_req  <= '0;
            r_s_we   <= 1'b0;
            r_m_ack  <= w_owner_oh;
            r_m_data <= w_rdata;
            r_m_err  <= 1'b0;
`ifdef RIB_TIMEOUT_EN
          end else if (r_wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
            r_state  <= StResp;
            r_s_req  <= '0;
            r_s_we   <= 1'b0;
            r_m_ack  <= w_owner_oh;
            r_m_data <= '0;
            r_m_err  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
          end
        end
        StResp: begin
          r_state  <= StIdle;
          r_rr_ptr <= r_owner;
          r_m_ack  <= '0;
          r_m_data <= '0;
          r_m_err  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign m_ack_o     = r_m_ack;
  assign m_data_o    = r_m_data;
  assign m_err_o     = r_m_err;
  assign s_req_o     = r_s_req;
  assign s_we_o      = r_s_we;
  assign s_addr_o    = r_addr;
  assign s_data_o    = r_wdata;
  assign hold_flag_o = (|(m_req_i & HOLD_MASK)) | ((r_state != StIdle) & HOLD_MASK[r_owner]);

endmodule

// File: tb/tb_rib_xbar.sv
// Directed self-checking bench for rib_xbar (4 masters, 6 slaves, TIMEOUT_CYC=8).
module tb_rib_xbar;

  logic         clk;
  logic         rst;
  logic [3:0]   m_req;
  logic [127:0] m_addr;
  logic [127:0] m_wdata;
  logic [3:0]   m_we;
  logic [31:0]  m_rdata;
  logic [3:0]   m_ack;
  logic         m_err;
  logic [5:0]   s_req;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic         s_we;
  logic [191:0] s_rdata;
  logic [5:0]   s_ack;
  logic         hold;

  int n_cmp;
  int n_bad;

  rib_xbar #(
    .NUM_M       (4),
    .NUM_S       (6),
    .HOLD_MASK   (4'b1101),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (m_req),
    .m_addr_i    (m_addr),
    .m_data_i    (m_wdata),
    .m_we_i      (m_we),
    .m_data_o    (m_rdata),
    .m_ack_o     (m_ack),
    .m_err_o     (m_err),
    .s_req_o     (s_req),
    .s_addr_o    (s_addr),
    .s_data_o    (s_wdata),
    .s_we_o      (s_we),
    .s_data_i    (s_rdata),
    .s_ack_i     (s_ack),
    .hold_flag_o (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_req   = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_we    = '0;
    s_rdata = '0;
    s_ack   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({s_req, s_we, m_ack, m_err, hold} !== 13'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0", {s_req, s_we, m_ack, m_err, hold});
    end
    n_cmp++;
    if ({s_addr, s_wdata, m_rdata} !== 96'b0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {s_addr, s_wdata, m_rdata});
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_read();
    m_req[0]          = 1'b1;
    m_addr[31:0]      = 32'h1000_0010;
    s_ack[1]          = 1'b1;
    s_rdata[63:32]    = 32'hDEAD_BEEF;
    tick();
    n_cmp++;
    if (s_req !== 6'b000010 || s_addr !== 32'h0000_0010 || s_we !== 1'b0 || m_ack !== 4'b0) begin
      n_bad++;
      $display("FAIL read_c1: s_req=%b s_addr=%h s_we=%b m_ack=%b want 000010 00000010 0 0000",
               s_req, s_addr, s_we, m_ack);
    end
    tick();
    n_cmp++;
    if (m_ack !== 4'b0001 || m_rdata !== 32'hDEAD_BEEF || m_err !== 1'b0 || s_req !== 6'b0) begin
      n_bad++;
      $display("FAIL read_c2: m_ack=%b data=%h err=%b s_req=%b want 0001 deadbeef 0 000000",
               m_ack, m_rdata, m_err, s_req);
    end
    clear_inputs();
    tick();
    n_cmp++;
    if (m_ack !== 4'b0 || m_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL read_c3: m_ack=%b data=%h want 0000 0", m_ack, m_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack;
    do_reset();
    m_req    = 4'b1111;
    s_ack[0] = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      exp_ack = 4'b0;
      if (c % 3 == 2) exp_ack[(c / 3) % 4] = 1'b1;
      n_cmp++;
      if (m_ack !== exp_ack) begin
        n_bad++;
        $display("FAIL rr_cycle%0d: m_ack=%b want %b", c, m_ack, exp_ack);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_write_wait();
    m_req[2]          = 1'b1;
    m_we[2]           = 1'b1;
    m_addr[95:64]     = 32'h4000_0008;
    m_wdata[95:64]    = 32'h5A5A_5A5A;
    s_rdata[159:128]  = 32'h1234_5678;
    s_ack[3]          = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_cmp++;
      if (s_we !== 1'b1 || s_req !== 6'b010000 || s_wdata !== 32'h5A5A_5A5A ||
          s_addr !== 32'h0000_0008 || m_ack !== 4'b0) begin
        n_bad++;
        $display("FAIL write_busy%0d: we=%b req=%b data=%h addr=%h ack=%b", c, s_we, s_req,
                 s_wdata, s_addr, m_ack);
      end
      s_ack[4] = (c == 4);
    end
    tick();
    n_cmp++;
    if (m_ack !== 4'b0100 || s_we !== 1'b0 || m_err !== 1'b0 || m_rdata !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL write_resp: ack=%b we=%b err=%b data=%h want 0100 0 0 12345678", m_ack,
               s_we, m_err, m_rdata);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_decode_err();
    m_req[1]      = 1'b1;
    m_addr[63:32] = 32'hF000_0000;
    tick();
    n_cmp++;
    if (m_ack !== 4'b0010 || m_err !== 1'b1 || m_rdata !== 32'h0 || s_req !== 6'b0) begin
      n_bad++;
      $display("FAIL decode_err: ack=%b err=%b data=%h s_req=%b want 0010 1 0 000000", m_ack,
               m_err, m_rdata, s_req);
    end
    clear_inputs();
    tick();
    n_cmp++;
    if (m_ack !== 4'b0 || m_err !== 1'b0) begin
      n_bad++;
      $display("FAIL decode_after: ack=%b err=%b want 0000 0", m_ack, m_err);
    end
  endtask

`ifdef RIB_TIMEOUT_EN
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      m_req[0]       = 1'b1;
      m_addr[31:0]   = 32'h2000_0000;
      s_rdata[95:64] = 32'hCAFE_0001;
      for (int c = 1; c <= 8; c++) begin
        tick();
        n_cmp++;
        if (s_req !== 6'b000100 || m_ack !== 4'b0) begin
          n_bad++;
          $display("FAIL timeout_busy p%0d c%0d: s_req=%b ack=%b", pass, c, s_req, m_ack);
        end
        s_ack[2] = (pass == 1) && (c == 8);
      end
      tick();
      n_cmp++;
      if (m_ack !== 4'b0001 || s_req !== 6'b0 || m_err !== (pass == 0) ||
          m_rdata !== ((pass == 0) ? 32'h0 : 32'hCAFE_0001)) begin
        n_bad++;
        $display("FAIL timeout_resp p%0d: ack=%b s_req=%b err=%b data=%h", pass, m_ack, s_req,
                 m_err, m_rdata);
      end
      clear_inputs();
      tick();
    end
  endtask
`else
  task automatic test_no_timeout();
    m_req[0]     = 1'b1;
    m_addr[31:0] = 32'h2000_0000;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 20 || c == 9) begin
        n_cmp++;
        if (s_req !== 6'b000100 || m_ack !== 4'b0) begin
          n_bad++;
          $display("FAIL wait_busy c%0d: s_req=%b ack=%b want 000100 0000", c, s_req, m_ack);
        end
      end
    end
    s_ack[2]       = 1'b1;
    s_rdata[95:64] = 32'hCAFE_0002;
    tick();
    n_cmp++;
    if (m_ack !== 4'b0001 || m_err !== 1'b0 || m_rdata !== 32'hCAFE_0002) begin
      n_bad++;
      $display("FAIL wait_resp: ack=%b err=%b data=%h want 0001 0 cafe0002", m_ack, m_err,
               m_rdata);
    end
    clear_inputs();
    tick();
  endtask
`endif

  task automatic test_hold();
    logic [3:0] seen;
    s_ack[0] = 1'b1;
    seen     = 4'b0;
    // Master 1 is not a stall-class master.
    m_req[1] = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      if (c > 0) tick();
      #1;
      seen[c] = hold;
    end
    m_req = '0;
    n_cmp++;
    if (seen[2:0] !== 3'b000) begin
      n_bad++;
      $display("FAIL hold_m1: hold over 3 cycles=%b want 000", seen[2:0]);
    end
    tick();
    m_req[3] = 1'b1;
    #1;
    seen[0] = hold;
    tick();
    seen[1] = hold;
    tick();
    n_cmp++;
    if (m_ack !== 4'b1000) begin
      n_bad++;
      $display("FAIL hold_m3_ack: ack=%b want 1000", m_ack);
    end
    m_req = '0;
    #1;
    seen[2] = hold;
    tick();
    seen[3] = hold;
    n_cmp++;
    if (seen !== 4'b0111) begin
      n_bad++;
      $display("FAIL hold_m3: hold idle/busy/resp/after=%b want 0111 (msb=after)", seen);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    m_req[0]     = 1'b1;
    m_addr[31:0] = 32'h5000_0000;
    tick();
    n_cmp++;
    if (s_req !== 6'b100000) begin
      n_bad++;
      $display("FAIL rstbusy_pre: s_req=%b want 100000", s_req);
    end
    #2;
    rst   = 1'b0;
    m_req = '0;
    #1;
    n_cmp++;
    if ({s_req, s_we, m_ack, m_err, hold} !== 13'b0 || {s_addr, s_wdata, m_rdata} !== 96'b0) begin
      n_bad++;
      $display("FAIL rstbusy_async: ctrl=%b data=%h want 0", {s_req, s_we, m_ack, m_err, hold},
               {s_addr, s_wdata, m_rdata});
    end
    tick();
    rst      = 1'b1;
    s_ack[5] = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (m_ack !== 4'b0 || s_req !== 6'b0) begin
      n_bad++;
      $display("FAIL rstbusy_after: ack=%b s_req=%b want 0", m_ack, s_req);
    end
    clear_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    clear_inputs();
    test_reset();
    test_read();
    test_round_robin();
    test_write_wait();
    test_decode_err();
`ifdef RIB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_hold();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout want finish");
    $fatal(1);
  end

endmodule
